// File: rtl/qu_prf_pkg.sv
// Qu core physical register file: shared types.
// Default geometry, register-id typedefs and the zero entry.
package qu_prf_pkg;

  localparam int RF_WIDTH_D = 32;
  localparam int RF_DEPTH_D = 128;
  localparam int PREG_AW    = $clog2(RF_DEPTH_D);
  localparam int PREG_ZERO  = 0;

  typedef logic [PREG_AW-1:0]    preg_addr_t;
  typedef logic [RF_WIDTH_D-1:0] preg_data_t;

endpackage

// File: rtl/prf_bypass_mux.sv
// Qu PRF read-port mux.
// Forwards same-cycle write data/ready over the stored entry.
module prf_bypass_mux #(
  parameter int AW     = 7,
  parameter int W      = 32,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]              i_rd_addr,
  input  logic [W-1:0]               i_st_data,
  input  logic                       i_st_ready,
  input  logic [NUM_WR-1:0]          i_wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]  i_wr_addr,
  input  logic [NUM_WR-1:0][W-1:0]   i_wr_data,
  output logic [W-1:0]               o_rd_data,
  output logic                       o_rd_ready
);

  // Stored value unless a write hits; later ports override earlier ones.
  always_comb begin
    o_rd_data  = i_st_data;
    o_rd_ready = i_st_ready;
    if (BYPASS != 0) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (i_wr_en[j] && (i_wr_addr[j] == i_rd_addr)) begin
          o_rd_data  = i_wr_data[j];
          o_rd_ready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prf_mp.sv
// Qu multi-ported physical register file.
// Prioritised writes, alloc/flush ready bits, bypassed reads.
module prf_mp
  import qu_prf_pkg::*;
#(
  parameter int RF_WIDTH  = RF_WIDTH_D,
  parameter int RF_DEPTH  = RF_DEPTH_D,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  localparam int AW       = $clog2(RF_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_RD-1:0][AW-1:0]         rd_addr,
  output logic [NUM_RD-1:0][RF_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]                 rd_ready,
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]         wr_addr,
  input  logic [NUM_WR-1:0][RF_WIDTH-1:0]   wr_data,
  input  logic [NUM_ALLOC-1:0]              alloc_en,
  input  logic [NUM_ALLOC-1:0][AW-1:0]      alloc_addr,
  input  logic                              flush,
  output logic [RF_DEPTH-1:0]               ready_vec
);

  logic [RF_WIDTH-1:0] r_mem [RF_DEPTH];
  logic [RF_DEPTH-1:0] r_ready;
  logic [NUM_WR-1:0]    w_wr_ok;
  logic [NUM_ALLOC-1:0] w_al_ok;

  // Drop writes and allocs aimed at the hardwired zero entry.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      w_wr_ok[j] = wr_en[j] &&
        !((ZERO_REG != 0) && (wr_addr[j] == AW'(PREG_ZERO)));
    end
    for (int k = 0; k < NUM_ALLOC; k++) begin
      w_al_ok[k] = alloc_en[k] &&
        !((ZERO_REG != 0) && (alloc_addr[k] == AW'(PREG_ZERO)));
    end
  end

  // Data store; ascending loop lets the highest port win a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < RF_DEPTH; e++) begin
        r_mem[e] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (w_wr_ok[j]) begin
          r_mem[wr_addr[j]] <= wr_data[j];
        end
      end
    end
  end

  // Ready bits: reset/flush set all, alloc clear beats write set.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ready <= '1;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (w_wr_ok[j]) begin
          r_ready[wr_addr[j]] <= 1'b1;
        end
      end
      for (int k = 0; k < NUM_ALLOC; k++) begin
        if (w_al_ok[k]) begin
          r_ready[alloc_addr[k]] <= 1'b0;
        end
      end
    end
  end

  assign ready_vec = r_ready;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [RF_WIDTH-1:0] w_data;
    logic                w_rdy;
    logic                w_zero;

    prf_bypass_mux #(
      .AW     (AW),
      .W      (RF_WIDTH),
      .NUM_WR (NUM_WR),
      .BYPASS (BYPASS)
    ) u_mux (
      .i_rd_addr  (rd_addr[i]),
      .i_st_data  (r_mem[rd_addr[i]]),
      .i_st_ready (r_ready[rd_addr[i]]),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .o_rd_data  (w_data),
      .o_rd_ready (w_rdy)
    );

    assign w_zero = (ZERO_REG != 0) &&
                    (rd_addr[i] == AW'(PREG_ZERO));
    assign rd_data[i]  = w_zero ? '0 : w_data;
    assign rd_ready[i] = w_zero | w_rdy;
  end

endmodule

// File: tb/tb_prf_mp.sv
// Bench for prf_mp: bypassed and non-bypassed copies
// driven together and compared with an array model.
module tb_prf_mp;
  import qu_prf_pkg::*;

  logic clk;
  logic rst;
  preg_addr_t [3:0] rd_addr;
  logic       [1:0] wr_en;
  preg_addr_t [1:0] wr_addr;
  preg_data_t [1:0] wr_data;
  logic       [1:0] alloc_en;
  preg_addr_t [1:0] alloc_addr;
  logic             flush;

  preg_data_t [3:0] b_data, n_data;
  logic       [3:0] b_rdy, n_rdy;
  logic     [127:0] b_vec, n_vec;

  int errs;
  int checks;

  preg_data_t m_data [128];
  bit         m_rdy  [128];

  prf_mp #(.BYPASS(1), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(b_data), .rd_ready(b_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .flush(flush), .ready_vec(b_vec)
  );

  prf_mp #(.BYPASS(0), .ZERO_REG(1)) dut_n (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(n_data), .rd_ready(n_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .flush(flush), .ready_vec(n_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] m_vec();
    logic [127:0] v;
    for (int e = 0; e < 128; e++) v[e] = m_rdy[e];
    return v;
  endfunction

  // What a read port should show given current stored model state.
  task automatic exp_read(input int i, input bit byp,
                          output preg_data_t d, output logic r);
    preg_addr_t a;
    a = rd_addr[i];
    d = m_data[a];
    r = m_rdy[a];
    if (byp) begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j] && wr_addr[j] == a) begin
          d = wr_data[j];
          r = 1'b1;
        end
      end
    end
    if (a == '0) begin
      d = '0;
      r = 1'b1;
    end
  endtask

  task automatic model_update();
    bit ah, wh;
    if (rst) begin
      for (int e = 0; e < 128; e++) begin
        m_data[e] = '0;
        m_rdy[e]  = 1'b1;
      end
    end else begin
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j] != '0)
          m_data[wr_addr[j]] = wr_data[j];
      for (int e = 1; e < 128; e++) begin
        ah = 0;
        wh = 0;
        for (int k = 0; k < 2; k++)
          if (alloc_en[k] && int'(alloc_addr[k]) == e) ah = 1;
        for (int j = 0; j < 2; j++)
          if (wr_en[j] && int'(wr_addr[j]) == e) wh = 1;
        if (flush) m_rdy[e] = 1'b1;
        else if (ah) m_rdy[e] = 1'b0;
        else if (wh) m_rdy[e] = 1'b1;
      end
      m_rdy[0] = 1'b1;
    end
  endtask

  task automatic step(input bit do_chk);
    preg_data_t d;
    logic r;
    #1;
    if (do_chk) begin
      for (int i = 0; i < 4; i++) begin
        exp_read(i, 1'b1, d, r);
        chk("byp_data", 128'(b_data[i]), 128'(d));
        chk("byp_rdy",  128'(b_rdy[i]),  128'(r));
        exp_read(i, 1'b0, d, r);
        chk("nob_data", 128'(n_data[i]), 128'(d));
        chk("nob_rdy",  128'(n_rdy[i]),  128'(r));
      end
      chk("byp_vec", b_vec, m_vec());
      chk("nob_vec", n_vec, m_vec());
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0;
    flush = 0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    alloc_en = '0;
    alloc_addr = '0;
    rd_addr = '0;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    idle();
    rst = 1;
    step(0);
    step(0);

    idle();
    rd_addr[0] = 7'd5;
    rd_addr[1] = 7'd127;
    #1;
    chk("rst_d5",   128'(b_data[0]), 128'(0));
    chk("rst_d127", 128'(n_data[1]), 128'(0));
    chk("rst_r127", 128'(b_rdy[1]),  128'(1));
    chk("rst_vec",  n_vec, {128{1'b1}});
    step(1);

    idle();
    wr_en[0] = 1;
    wr_addr[0] = 7'd7;
    wr_data[0] = 32'hDEADBEEF;
    rd_addr[0] = 7'd7;
    #1;
    chk("nob_same", 128'(n_data[0]), 128'(0));
    chk("byp_same", 128'(b_data[0]), 128'(32'hDEADBEEF));
    step(1);
    idle();
    rd_addr[0] = 7'd7;
    #1;
    chk("nob_next", 128'(n_data[0]), 128'(32'hDEADBEEF));
    chk("nob_nrdy", 128'(n_rdy[0]),  128'(1));
    step(1);

    idle();
    wr_en = 2'b11;
    wr_addr[0] = 7'd9;
    wr_data[0] = 32'h11;
    wr_addr[1] = 7'd9;
    wr_data[1] = 32'h22;
    rd_addr[0] = 7'd9;
    #1;
    chk("conf_byp", 128'(b_data[0]), 128'(32'h22));
    step(1);
    idle();
    rd_addr[0] = 7'd9;
    #1;
    chk("conf_st", 128'(n_data[0]), 128'(32'h22));
    step(1);

    idle();
    alloc_en[0] = 1;
    alloc_addr[0] = 7'd12;
    step(1);
    idle();
    rd_addr[0] = 7'd12;
    #1;
    chk("al_rdy", 128'(b_rdy[0]), 128'(0));
    step(1);
    idle();
    wr_en[0] = 1;
    wr_addr[0] = 7'd12;
    wr_data[0] = 32'h5;
    alloc_en[0] = 1;
    alloc_addr[0] = 7'd12;
    step(1);
    idle();
    rd_addr[0] = 7'd12;
    #1;
    chk("alw_rdy",  128'(n_rdy[0]),  128'(0));
    chk("alw_data", 128'(n_data[0]), 128'(5));
    step(1);
    idle();
    flush = 1;
    alloc_en[0] = 1;
    alloc_addr[0] = 7'd20;
    step(1);
    idle();
    #1;
    chk("fl_vec", b_vec, {128{1'b1}});
    step(1);

    idle();
    wr_en[0] = 1;
    wr_addr[0] = '0;
    wr_data[0] = 32'hFFFF;
    alloc_en[0] = 1;
    alloc_addr[0] = '0;
    rd_addr[0] = '0;
    #1;
    chk("z_data_w", 128'(b_data[0]), 128'(0));
    chk("z_rdy_w",  128'(b_rdy[0]),  128'(1));
    step(1);
    idle();
    #1;
    chk("z_data", 128'(n_data[0]), 128'(0));
    chk("z_vec0", 128'(b_vec[0]),  128'(1));
    step(1);

    idle();
    alloc_en[0] = 1;
    alloc_addr[0] = 7'd30;
    wr_en[0] = 1;
    wr_addr[0] = 7'd31;
    wr_data[0] = 32'hAB;
    rst = 1;
    step(1);
    idle();
    rd_addr[0] = 7'd30;
    rd_addr[1] = 7'd31;
    #1;
    chk("mr_r30", 128'(n_rdy[0]),  128'(1));
    chk("mr_d31", 128'(n_data[1]), 128'(0));
    chk("mr_r31", 128'(b_rdy[1]),  128'(1));
    step(1);

    for (int c = 0; c < 400; c++) begin
      idle();
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 4; i++)
        rd_addr[i] = ($urandom_range(0, 3) == 0) ?
          7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
      for (int j = 0; j < 2; j++) begin
        wr_en[j]   = 1'($urandom_range(0, 1));
        wr_addr[j] = 7'($urandom_range(0, 15));
        wr_data[j] = $urandom;
      end
      for (int k = 0; k < 2; k++) begin
        alloc_en[k]   = ($urandom_range(0, 3) == 0);
        alloc_addr[k] = 7'($urandom_range(0, 15));
      end
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
